outbuf_fifo: RTL and testbench
==============================

OUTBUF_FIFO -- requirements
Module: outbuf_fifo

Interface
REQ-001 Parameter DATA_W, default 16: width of one output word.
REQ-002 Parameter DEPTH, default 8: number of entries; power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port outbuf_write, input, 1: write request from the output-buffer control FSM.
REQ-006 Port outbuf_din, input, DATA_W: word to write, signed two's complement.
REQ-007 Port outbuf_full, output, 1: buffer holds DEPTH words; drives the control FSM stall.
REQ-008 Port outbuf_empty, output, 1: buffer holds zero words.
REQ-009 Port rd_ready, input, 1: downstream consumer can accept a word this cycle.
REQ-010 Port rd_valid, output, 1: rd_data holds a valid word.
REQ-011 Port rd_data, output, DATA_W: head-of-queue word.
REQ-012 Port outbuf_count, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 Port overflow_err, output, 1: sticky flag, set by a write attempted while full.

Function
REQ-014 Storage: DEPTH x DATA_W register array; write pointer and read pointer, each log2(DEPTH) bits; occupancy counter, log2(DEPTH)+1 bits.
REQ-015 Write accept: the block accepts a write when outbuf_write=1 and outbuf_full=1 is false at the clock edge. It stores the word at wptr, then wptr increments modulo DEPTH.
REQ-016 Write while full: the word is dropped, pointers and count are unchanged, and overflow_err goes to 1 at the next edge.
REQ-017 Write while full with a pop in the same cycle: the write is still dropped, because acceptance depends only on outbuf_full at the start of the cycle.
REQ-018 Read interface is first-word-fall-through.
  - rd_valid = ~outbuf_empty.
  - rd_data = mem[rptr], combinational from registered state.
REQ-019 Pop: occurs when rd_valid=1 and rd_ready=1; rptr increments modulo DEPTH.
REQ-020 rd_data is don't-care when rd_valid=0; the bench does not check it.
REQ-021 Count update per edge:
  - accepted write only: count+1.
  - pop only: count-1.
  - both, or neither: count unchanged.
REQ-022 outbuf_full = (count==DEPTH) and outbuf_empty = (count==0), both derived from the registered count with no combinational input paths.
REQ-023 Latency: a word accepted at edge N drives rd_valid=1 and rd_data in the cycle after edge N. A write to an empty buffer cannot be popped in its own cycle.
REQ-024 Ordering: words leave in strict write order; pointer wrap-around is transparent to this order.
REQ-025 rd_ready=1 while empty has no effect.
REQ-026 Stall handshake: the control FSM holds outbuf_write until outbuf_full=0. A single pop therefore unblocks exactly one pending write on the following edge.

Reset
REQ-027 While rst=1 at a clock edge, the block sets wptr=0, rptr=0, count=0 and overflow_err=0, which gives outbuf_empty=1, outbuf_full=0 and rd_valid=0.
REQ-028 Array contents are not reset.
REQ-029 Reset overrides simultaneous write and pop. Reset mid-operation discards all queued words, and rd_valid=0 from the cycle after the reset edge.

Configuration
REQ-030 Macro OUTBUF_RELU_EN, when defined: an accepted word with MSB=1 is stored as all-zeros; non-negative words are stored unchanged.
REQ-031 Macro OUTBUF_RELU_EN, when undefined: outbuf_din is stored bit-exact.
REQ-032 The macro affects no other behaviour, and all flags, handshakes and timing are identical in both builds.

Verification (DATA_W=16, DEPTH=8)
REQ-033 Single word: reset, write 0x0005 for one cycle -> next cycle rd_valid=1, rd_data=0x0005, count=1; pop -> empty=1, count=0.
REQ-034 Fill and overflow: 8 writes 0x0001..0x0008 with rd_ready=0 -> full=1, count=8; a 9th write of 0x0009 -> dropped, overflow_err=1; draining then yields 0x0001..0x0008 in order.
REQ-035 Wrap-around and simultaneous access: stream 20 words with rd_ready=1 and a write every cycle -> output sequence equals input sequence, count stays at 1 after the first word, full is never asserted.
REQ-036 Full plus simultaneous write and pop: at count=8, drive outbuf_write=1 and rd_ready=1 together -> pop occurs, write is dropped, count=7, overflow_err=1.
REQ-037 Reset mid-stream: count=5, assert rst for one cycle -> count=0, empty=1, rd_valid=0, overflow_err=0; the next write of 0x00AA is the first word read.
REQ-038 ReLU build: write 0xFFFE then 0x0003 -> reads 0x0000, 0x0003 with OUTBUF_RELU_EN defined; reads 0xFFFE, 0x0003 without it.

Source files
------------

// File: rtl/outbuf_fifo_if.sv
// Output-buffer bus: control-FSM write side with full/empty/count/overflow status,
// plus a first-word-fall-through valid/ready read side toward the consumer.
interface outbuf_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    logic                       outbuf_write;
    logic [DATA_W-1:0]          outbuf_din;
    logic                       outbuf_full;
    logic                       outbuf_empty;
    logic                       rd_ready;
    logic                       rd_valid;
    logic [DATA_W-1:0]          rd_data;
    logic [$clog2(DEPTH):0]     outbuf_count;
    logic                       overflow_err;

    // master: producer/consumer side that drives writes and rd_ready
    modport master (
        output outbuf_write, outbuf_din, rd_ready,
        input  outbuf_full, outbuf_empty, rd_valid, rd_data, outbuf_count, overflow_err
    );

    modport slave (
        input  outbuf_write, outbuf_din, rd_ready,
        output outbuf_full, outbuf_empty, rd_valid, rd_data, outbuf_count, overflow_err
    );
endinterface

// File: rtl/outbuf_fifo.sv
// FWFT output FIFO; a word written at edge N is visible on rd_data the cycle after, writes
// while full are dropped and set sticky overflow_err. `OUTBUF_RELU_EN clamps negative words to 0.
module outbuf_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    outbuf_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic              ovf;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              pop;
    logic [DATA_W-1:0] din_st;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    // acceptance looks only at the registered full flag, so a same-cycle pop never frees a slot
    assign wr_acc = bus.outbuf_write & ~full;
    assign pop    = ~empty & bus.rd_ready;

`ifdef OUTBUF_RELU_EN
    assign din_st = bus.outbuf_din[DATA_W-1] ? '0 : bus.outbuf_din;
`else
    assign din_st = bus.outbuf_din;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr] <= din_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.outbuf_write && full)
                ovf <= 1'b1;
        end
    end

    assign bus.outbuf_full  = full;
    assign bus.outbuf_empty = empty;
    assign bus.outbuf_count = count;
    assign bus.overflow_err = ovf;
    assign bus.rd_valid     = ~empty;
    assign bus.rd_data      = mem[rptr];
endmodule

// File: tb/tb_outbuf_fifo.sv
// Directed bench for outbuf_fifo (DATA_W=16, DEPTH=8) with immediate-assertion checks.
module tb_outbuf_fifo;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_neg;

    outbuf_fifo_if #(.DATA_W(16), .DEPTH(8)) bus ();

    outbuf_fifo #(.DATA_W(16), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.outbuf_write = 1'b0;
        bus.outbuf_din   = '0;
        bus.rd_ready     = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_empty", bus.outbuf_empty, 1);
        chk("rst_full",  bus.outbuf_full,  0);
        chk("rst_valid", bus.rd_valid,     0);
        chk("rst_count", bus.outbuf_count, 0);
        chk("rst_ovf",   bus.overflow_err, 0);

        // single word
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h0005;
        tick;
        bus.outbuf_write = 1'b0;
        chk("single_valid", bus.rd_valid,     1);
        chk("single_data",  bus.rd_data,      16'h0005);
        chk("single_count", bus.outbuf_count, 1);
        bus.rd_ready = 1'b1;
        tick;
        bus.rd_ready = 1'b0;
        chk("single_pop_empty", bus.outbuf_empty, 1);
        chk("single_pop_count", bus.outbuf_count, 0);

        // write into empty with rd_ready high: not poppable in its own cycle
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h0077; bus.rd_ready = 1'b1;
        tick;
        bus.outbuf_write = 1'b0;
        chk("empty_wr_rd_count", bus.outbuf_count, 1);
        chk("empty_wr_rd_data",  bus.rd_data,      16'h0077);
        tick;
        chk("late_pop_count", bus.outbuf_count, 0);
        tick;
        chk("rdy_while_empty_count", bus.outbuf_count, 0);
        chk("rdy_while_empty_valid", bus.rd_valid,     0);
        bus.rd_ready = 1'b0;

        // fill and overflow
        for (int i = 1; i <= 8; i++) begin
            bus.outbuf_write = 1'b1; bus.outbuf_din = 16'(i);
            tick;
        end
        bus.outbuf_write = 1'b0;
        chk("fill_full",  bus.outbuf_full,  1);
        chk("fill_count", bus.outbuf_count, 8);
        chk("fill_ovf0",  bus.overflow_err, 0);
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h0009;
        tick;
        bus.outbuf_write = 1'b0;
        chk("ovf_set",   bus.overflow_err, 1);
        chk("ovf_count", bus.outbuf_count, 8);
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", bus.rd_valid, 1);
            chk("drain_data",  bus.rd_data,  i);
            tick;
        end
        bus.rd_ready = 1'b0;
        chk("drain_empty", bus.outbuf_empty, 1);
        chk("ovf_sticky",  bus.overflow_err, 1);

        // streaming with wrap-around
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.outbuf_write = 1'b1; bus.outbuf_din = 16'(16'h0100 + k);
            if (k > 0) chk("stream_data", bus.rd_data, 16'h0100 + k - 1);
            tick;
            chk("stream_count", bus.outbuf_count, 1);
            chk("stream_full",  bus.outbuf_full,  0);
        end
        bus.outbuf_write = 1'b0;
        chk("stream_last", bus.rd_data, 16'h0113);
        tick;
        bus.rd_ready = 1'b0;
        chk("stream_end_empty", bus.outbuf_empty, 1);

        // full with simultaneous write and pop
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_clears_ovf", bus.overflow_err, 0);
        for (int i = 1; i <= 8; i++) begin
            bus.outbuf_write = 1'b1; bus.outbuf_din = 16'(16'h0010 + i);
            tick;
        end
        bus.outbuf_din = 16'h0099; bus.rd_ready = 1'b1;
        tick;
        bus.outbuf_write = 1'b0; bus.rd_ready = 1'b0;
        chk("fullwr_count", bus.outbuf_count, 7);
        chk("fullwr_ovf",   bus.overflow_err, 1);
        chk("fullwr_head",  bus.rd_data,      16'h0012);
        chk("fullwr_full",  bus.outbuf_full,  0);
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h0055;
        tick;
        bus.outbuf_write = 1'b0;
        chk("unblock_count", bus.outbuf_count, 8);

        // reset mid-stream at count=5
        bus.rd_ready = 1'b1;
        tick; tick; tick;
        bus.rd_ready = 1'b0;
        chk("mid_count5", bus.outbuf_count, 5);
        rst = 1'b1; bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h0033; bus.rd_ready = 1'b1;
        tick;
        rst = 1'b0; bus.outbuf_write = 1'b0; bus.rd_ready = 1'b0;
        chk("mid_rst_count", bus.outbuf_count, 0);
        chk("mid_rst_empty", bus.outbuf_empty, 1);
        chk("mid_rst_valid", bus.rd_valid,     0);
        chk("mid_rst_ovf",   bus.overflow_err, 0);
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'h00AA;
        tick;
        bus.outbuf_write = 1'b0;
        chk("post_rst_data",  bus.rd_data,      16'h00AA);
        chk("post_rst_count", bus.outbuf_count, 1);
        bus.rd_ready = 1'b1;
        tick;
        bus.rd_ready = 1'b0;

        // negative word handling
`ifdef OUTBUF_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFFE;
`endif
        bus.outbuf_write = 1'b1; bus.outbuf_din = 16'hFFFE;
        tick;
        bus.outbuf_din = 16'h0003;
        tick;
        bus.outbuf_write = 1'b0;
        chk("relu_neg", bus.rd_data, exp_neg);
        bus.rd_ready = 1'b1;
        tick;
        chk("relu_pos", bus.rd_data, 16'h0003);
        tick;
        bus.rd_ready = 1'b0;
        chk("relu_empty", bus.outbuf_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
